// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter's sel output also drives the select pins of the shared mux_4x1.
interface mux_rr_arbiter_if;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;

    modport master (output en, output req, input gnt, input sel, input busy);
    modport slave  (input en, input req, output gnt, output sel, output busy);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner sequencer for a shared 4:1 mux with a bounded hold time.
// All outputs are registered, so there is no combinational path from req to gnt.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic             clk,
    input logic             rst_n,
    mux_rr_arbiter_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [1:0] ptr;

    logic [3:0] others;
    logic [1:0] pick_all;
    logic [1:0] pick_other;
    logic [1:0] new_owner;
    logic       do_grant;
    logic       to_idle;

    // First set bit of r, scanning from start upward modulo 4; start if none.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        pick = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    assign others     = bus.req & ~bus.gnt;
    assign pick_all   = pick(bus.req, ptr);
    assign pick_other = pick(others, ptr);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        do_grant  = 1'b0;
        to_idle   = 1'b0;
        new_owner = pick_all;
        case (state)
            IDLE: do_grant = bus.en && (|bus.req);
            GRANT: begin
                if (!bus.en) begin
                    to_idle = 1'b1;
                end else if (!bus.req[bus.sel]) begin
                    // Voluntary release hands straight to the next requester, no idle bubble.
                    do_grant = |bus.req;
                    to_idle  = ~(|bus.req);
                end else if (hold_cnt == HOLD_LAST && (|others)) begin
                    do_grant  = 1'b1;
                    new_owner = pick_other;
                end
            end
            default: to_idle = 1'b1;
        endcase
    end

    // NOTE: reset is asynchronous, so outputs clear the moment rst_n falls, even mid-grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus.gnt  <= 4'b0000;
            bus.sel  <= 2'b00;
            bus.busy <= 1'b0;
            hold_cnt <= 8'd0;
            ptr      <= 2'd0;
        end else if (do_grant) begin
            // NOTE: non-blocking assignments let every register see pre-edge values, whatever the statement order.
            state    <= GRANT;
            bus.gnt  <= 4'b0001 << new_owner;
            bus.sel  <= new_owner;
            bus.busy <= 1'b1;
            hold_cnt <= 8'd0;
            ptr      <= new_owner + 2'd1;
        end else if (to_idle) begin
            state    <= IDLE;
            bus.gnt  <= 4'b0000;
            bus.busy <= 1'b0;
        end else if (state == GRANT && hold_cnt != HOLD_LAST) begin
            // Saturate so a late competitor triggers rotation on its first edge.
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Drives three arbiters (MAX_HOLD = 8, 4, 1) side by side and compares every cycle
// against an ownership model built from the round-robin rules.
module tb_mux_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] req_v  [3];
    logic       en_v   [3];
    logic [3:0] gnt_v  [3];
    logic [1:0] sel_v  [3];
    logic       busy_v [3];

    mux_rr_arbiter_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign bus[g].req = req_v[g];
        assign bus[g].en  = en_v[g];
        assign gnt_v[g]   = bus[g].gnt;
        assign sel_v[g]   = bus[g].sel;
        assign busy_v[g]  = bus[g].busy;

        mux_rr_arbiter #(.MAX_HOLD(g == 0 ? 8 : (g == 1 ? 4 : 1))) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g].slave)
        );
    end

    // Model: owner is -1 when nobody holds the mux; held counts cycles kept so far.
    int max_hold [3] = '{8, 4, 1};
    int m_owner  [3];
    int m_sel    [3];
    int m_ptr    [3];
    int m_held   [3];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int first_req(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_owner[i] = -1;
            m_sel[i]   = 0;
            m_ptr[i]   = 0;
            m_held[i]  = 0;
        end
    endtask

    task automatic model_give(input int i, input int o);
        m_owner[i] = o;
        m_sel[i]   = o;
        m_held[i]  = 0;
        m_ptr[i]   = (o + 1) % 4;
    endtask

    task automatic model_step(input int i);
        logic [3:0] r;
        logic [3:0] rest;
        int         p;
        r = req_v[i];
        if (m_owner[i] < 0) begin
            if (en_v[i] && r != 4'b0) model_give(i, first_req(r, m_ptr[i]));
        end else if (!en_v[i]) begin
            m_owner[i] = -1;
        end else if (!r[m_owner[i]]) begin
            p = first_req(r, m_ptr[i]);
            if (p >= 0) model_give(i, p);
            else m_owner[i] = -1;
        end else begin
            rest = r;
            rest[m_owner[i]] = 1'b0;
            if (m_held[i] >= max_hold[i] - 1 && rest != 4'b0)
                model_give(i, first_req(rest, m_ptr[i]));
            else
                m_held[i]++;
        end
    endtask

    function automatic logic [3:0] model_gnt(input int i);
        logic [3:0] e;
        e = 4'b0000;
        if (m_owner[i] >= 0) e[m_owner[i]] = 1'b1;
        return e;
    endfunction

    // One clock edge: advance the model with pre-edge inputs, then compare 1 ns later.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("gnt[%0d]", i), 8'(gnt_v[i]), 8'(model_gnt(i)));
            check($sformatf("sel[%0d]", i), 8'(sel_v[i]), 8'(m_sel[i]));
            check($sformatf("busy[%0d]", i), 8'(busy_v[i]), 8'(m_owner[i] >= 0));
            check($sformatf("onehot[%0d]", i), 8'($onehot0(gnt_v[i])), 8'd1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) en_v[i] = 1'b1;
        req_v[0] = 4'b0100;
        req_v[1] = 4'b1111;
        req_v[2] = 4'b0101;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_gnt[%0d]", i), 8'(gnt_v[i]), 8'h00);
            check($sformatf("rst_sel[%0d]", i), 8'(sel_v[i]), 8'h00);
            check($sformatf("rst_busy[%0d]", i), 8'(busy_v[i]), 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Lone requester never rotates; full contention rotates every 4; MAX_HOLD=1 alternates.
        for (int k = 0; k < 20; k++) begin
            tick();
            check("single_gnt", 8'(gnt_v[0]), 8'h04);
            check("single_sel", 8'(sel_v[0]), 8'h02);
            check("contend_gnt", 8'(gnt_v[1]), 8'(4'b0001 << ((k / 4) % 4)));
            check("contend_sel", 8'(sel_v[1]), 8'((k / 4) % 4));
            check("alt_gnt", 8'(gnt_v[2]), (k % 2 == 0) ? 8'h01 : 8'h04);
            check("alt_sel", 8'(sel_v[2]), (k % 2 == 0) ? 8'h00 : 8'h02);
        end
        req_v[0] = 4'b0000;
        tick();
        check("drop_gnt", 8'(gnt_v[0]), 8'h00);
        check("drop_busy", 8'(busy_v[0]), 8'h00);
        check("drop_sel", 8'(sel_v[0]), 8'h02);

        // Asynchronous reset between edges while instances 1 and 2 are granting.
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_gnt[%0d]", i), 8'(gnt_v[i]), 8'h00);
            check($sformatf("async_sel[%0d]", i), 8'(sel_v[i]), 8'h00);
            check($sformatf("async_busy[%0d]", i), 8'(busy_v[i]), 8'h00);
        end
        req_v[0] = 4'b0010;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_gnt", 8'(gnt_v[0]), 8'h02);
        check("post_rst_sel", 8'(sel_v[0]), 8'h01);

        // Owner 1 releases early; 2 is absent so 3 takes over with a fresh hold count.
        req_v[0] = 4'b1011;
        tick();
        tick();
        req_v[0] = 4'b1001;
        tick();
        check("handoff_gnt", 8'(gnt_v[0]), 8'h08);
        check("handoff_sel", 8'(sel_v[0]), 8'h03);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("handoff_hold", 8'(gnt_v[0]), 8'h08);
        end
        tick();
        check("handoff_rotate", 8'(gnt_v[0]), 8'h01);

        // Enable gating, and the pointer surviving a revoke.
        req_v[0] = 4'b0001;
        en_v[0]  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("en_off_gnt", 8'(gnt_v[0]), 8'h00);
        end
        en_v[0] = 1'b1;
        tick();
        check("en_on_gnt", 8'(gnt_v[0]), 8'h01);
        check("en_on_sel", 8'(sel_v[0]), 8'h00);
        en_v[0] = 1'b0;
        tick();
        check("revoke_gnt", 8'(gnt_v[0]), 8'h00);
        req_v[0] = 4'b0011;
        en_v[0]  = 1'b1;
        tick();
        check("reenable_gnt", 8'(gnt_v[0]), 8'h02);

        // Random traffic against the model; requests persist a few cycles on average.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) req_v[i] = 4'($urandom);
                en_v[i] = ($urandom_range(0, 9) != 0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one mux_4x1 datapath between four requesters.
- Sequences ownership: drives the mux select, a one-hot grant back to the requesters, and a busy flag.
- Bounds each owner's hold time so no requester can starve the others.
- Sits directly in front of the mux select pins; its sel output feeds the mux sel input.

Parameters:
- MAX_HOLD, 8: max consecutive grant cycles while another request is pending. Legal range 1..255; the hold counter is 8 bits wide.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset.
- en  input  1  arbiter enable; 0 blocks new grants and revokes the current one.
- req  input  4  request vector; bit i = requester i (maps to mux input a/b/c/d for i=0/1/2/3).
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select, registered; equals the binary index of the current/last owner.
- busy  output  1  1 while in GRANT state.

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous, any time incl. mid-grant):
  - gnt=0000, sel=00, busy=0.
  - State IDLE, hold_cnt=0, priority pointer ptr=0.
  - Outputs clear immediately, without waiting for a clock edge.
- All state and outputs are registered; there are no combinational paths from req to gnt.
- Pick function: the first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- IDLE:
  - gnt=0; sel holds the last owner.
  - If en=1 and req≠0: next state GRANT, owner=pick, gnt=onehot(owner), sel=owner, busy=1, hold_cnt=0, ptr=owner+1 mod 4.
  - Latency: req sampled at edge N gives gnt valid after edge N (1 cycle).
- GRANT, evaluated each edge in this priority order:
  1. en=0: next IDLE, gnt=0, busy=0, ptr unchanged.
  2. req[owner]=0 (voluntary release):
     - If other requests are present, grant pick directly at this edge with no idle bubble.
     - Otherwise go to IDLE.
  3. hold_cnt == MAX_HOLD-1 and any other req bit set (forced rotation): grant pick among the other requesters at this edge.
  4. Otherwise keep the grant and increment hold_cnt.
     - With no contention, hold_cnt saturates at MAX_HOLD-1.
     - A forced rotation then triggers on the first edge a competitor appears.
- Every new grant, including a hand-off, resets hold_cnt=0 and sets ptr=new_owner+1 mod 4.
- gnt is always one-hot or zero and never changes by more than one owner per edge.
- sel changes only on a new grant.
- MAX_HOLD=1: under contention the grant rotates every cycle.
- Requests that drop before being granted are simply not considered; nothing is latched.
- req≠0 while en=0: no grant. The first grant occurs one edge after en returns to 1.

Test Plan:
- Reset: assert rst_n=0 mid-grant between clock edges -> gnt=0000, sel=00, busy=0 immediately. After release with req=0010, gnt=0010 and sel=01 one edge later.
- Single requester: req=0100 held 20 cycles, MAX_HOLD=8 -> gnt=0100 and sel=10 continuously, no rotation. Drop req -> next edge gnt=0000, busy=0, sel stays 10.
- Full contention: req=1111 constant from reset, MAX_HOLD=4 -> owners 0,1,2,3,0... each exactly 4 cycles, sel 00,01,10,11. Hand-offs have no idle cycle and gnt is always one-hot.
- Early release hand-off: owner 1 granted, req=1011. Drop req[1] after 2 cycles -> next edge grants 3 (sel=11), skipping absent requester 2, with hold_cnt restarted.
- Enable: en=0 with req=0001 -> gnt stays 0. en=1 -> gnt=0001 after one edge. en=0 during the grant -> gnt=0000 next edge, ptr unchanged, so re-enable grants 1 before 0 if req=0011.
- MAX_HOLD=1 with req=0101 -> gnt alternates 0001/0100 every cycle; sel alternates 00/10.
